// File: rtl/vga_sync_if.sv
// Pixel-coordinate / colour / sync bundle between vga_sync (master) and its
// consumers: the renderer (colour back in) and the DAC pins (sync + colour out).
interface vga_sync_if;
    logic [9:0] x_crd;
    logic [9:0] y_crd;
    logic       red_in;
    logic       green_in;
    logic       blue_in;
    logic       pix_tick;
    logic       frame_tick;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       red;
    logic       green;
    logic       blue;

    // Timing generator side
    modport master (
        input  red_in, green_in, blue_in,
        output x_crd, y_crd, pix_tick, frame_tick, video_on,
               hsync, vsync, red, green, blue
    );

    // Renderer / DAC side
    modport slave (
        output red_in, green_in, blue_in,
        input  x_crd, y_crd, pix_tick, frame_tick, video_on,
               hsync, vsync, red, green, blue
    );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, h/v counters, registered
// active-low syncs and blanked colour with a fixed one-clock latency.
// Optional: define VGA_BORDER_EN to force a white one-pixel frame around
// the active area (monitor-alignment aid).
module vga_sync #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    vga_sync_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned CNT_W   = 10;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
    localparam logic [CNT_W-1:0] H_ALAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ALAST  = CNT_W'(V_ACTIVE - 1);
`endif

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             pix_tick_q, pix_tick_d;
    logic             frame_tick_q, frame_tick_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             active_c;

    // Pixel-rate divider and raster counters; counters move only on pix_tick
    always_comb begin
        div_cnt_d    = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        pix_tick_d   = (div_cnt_q == DIV_LAST);
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_tick_d = 1'b0;
        if (pix_tick_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d      = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + CNT_W'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    // Sync, active flag and blanked colour from the current counters
    always_comb begin
        active_c = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        video_on_d = active_c;
        hsync_d    = ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vsync_d    = ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        rgb_d      = active_c ? {vga.red_in, vga.green_in, vga.blue_in} : 3'b000;
`ifdef VGA_BORDER_EN
        if (active_c && ((h_cnt_q == '0) || (h_cnt_q == H_ALAST) ||
                         (v_cnt_q == '0) || (v_cnt_q == V_ALAST))) begin
            rgb_d = 3'b111;
        end
`else
`endif
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            pix_tick_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            video_on_q   <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            rgb_q        <= 3'b000;
        end else begin
            div_cnt_q    <= div_cnt_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            pix_tick_q   <= pix_tick_d;
            frame_tick_q <= frame_tick_d;
            video_on_q   <= video_on_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
        end
    end

    assign vga.x_crd      = h_cnt_q;
    assign vga.y_crd      = v_cnt_q;
    assign vga.pix_tick   = pix_tick_q;
    assign vga.frame_tick = frame_tick_q;
    assign vga.video_on   = video_on_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.red        = rgb_q[2];
    assign vga.green      = rgb_q[1];
    assign vga.blue       = rgb_q[0];

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Timing generator for the 640x480@60 Hz VGA path; the producing end of the x_crd/y_crd pixel-coordinate interface consumed by the game renderer.
- Divides the system clock down to the pixel rate and runs horizontal and vertical counters.
- Drives coordinates to the renderer and takes its red/green/blue bits back.
- Emits hsync/vsync and blanked, sync-aligned colour outputs to the DAC pins, plus a once-per-frame tick for game logic.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz -> 25 MHz); must be >= 2.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- red_in  in  1  renderer red for current x_crd/y_crd
- green_in  in  1  renderer green
- blue_in  in  1  renderer blue
- x_crd  out  10  current horizontal count (0..H_TOTAL-1)
- y_crd  out  10  current vertical count (0..V_TOTAL-1)
- pix_tick  out  1  one-clk pulse per pixel
- frame_tick  out  1  one-clk pulse per frame
- video_on  out  1  registered active-area flag
- hsync  out  1  registered, active-low
- vsync  out  1  registered, active-low
- red  out  1  registered, blanked colour
- green  out  1  registered, blanked colour
- blue  out  1  registered, blanked colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All counters are 10-bit unsigned.
- Reset (async, any time, including mid-frame): div_cnt=0, h_cnt=0, v_cnt=0; pix_tick=0, frame_tick=0, video_on=0; hsync=1, vsync=1; red=green=blue=0. Counting restarts from pixel (0,0) on the first clk after rst is released.
- div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick is registered and is 1 exactly in the clk after div_cnt==CLK_DIV-1, so it is high 1 of every CLK_DIV clks.
- Counters advance only in cycles where pix_tick==1:
  - h_cnt==H_TOTAL-1: h_cnt<=0, and v_cnt advances.
  - v_cnt advance: v_cnt==V_TOTAL-1 -> v_cnt<=0; otherwise v_cnt+1.
  - Otherwise h_cnt+1.
- frame_tick: registered one-clk pulse, asserted in the clk after the pix_tick cycle in which both counters wrap (the pixel at (H_TOTAL-1, V_TOTAL-1)).
- x_crd=h_cnt and y_crd=v_cnt, driven directly with zero latency. This lets the combinational renderer return colour within the same clk.
- Registered outputs are all updated every clk from the current counters, giving a fixed 1-clk latency that keeps sync and colour aligned:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE); video_on <= active.
  - hsync <= ~(h_cnt >= H_ACTIVE+H_FP && h_cnt < H_ACTIVE+H_FP+H_SYNC).
  - vsync <= ~(v_cnt >= V_ACTIVE+V_FP && v_cnt < V_ACTIVE+V_FP+V_SYNC).
  - {red,green,blue} <= active ? {red_in,green_in,blue_in} : 3'b000.
- Colour inputs are sampled every clk and are never latched across pixels.
- Boundary cases:
  - x=639 is visible and x=640 is blanked; y=479 is visible and y=480 is blanked.
  - Counters never exceed H_TOTAL-1 or V_TOTAL-1.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: for active pixels with h_cnt==0, h_cnt==H_ACTIVE-1, v_cnt==0 or v_cnt==V_ACTIVE-1, red/green/blue <= 3'b111, overriding the renderer. Used as a monitor-alignment aid.
- Undefined: the renderer colour passes through unchanged in the active area. No border logic is synthesised.

Test Plan:
- Reset: hold rst=1 for 10 clks -> hsync=1, vsync=1, video_on=0, rgb=000, x_crd=0, y_crd=0, both ticks 0. Release -> first pix_tick 4 clks later.
- Line timing, defaults: hsync falls 1 clk after h_cnt reaches 656 and stays low 96*4=384 clks. Line period is 3200 clks. video_on is high for 640*4=2560 clks per visible line.
- Frame timing: vsync is low for exactly 2 lines (6400 clks), starting when v_cnt=490. frame_tick period is 800*525*4 = 1,680,000 clks. x_crd/y_crd read 0/0 in the clk after frame_tick.
- Blanking: tie red_in=green_in=blue_in=1 -> rgb=111 while video_on=1, and rgb=000 at x_crd=640..799 and y_crd=480..524.
- Mid-frame reset: assert rst at (x,y)=(300,200) -> all outputs return to reset values immediately (async). After release, counting resumes from (0,0) with no partial-line glitch on hsync.
- VGA_BORDER_EN defined, rgb inputs=000 -> rgb=111 at x=0, x=639, y=0 and y=479, and 000 elsewhere. Macro undefined -> 000 everywhere.
